// File: rtl/fifo8x9_ctrl_if.sv
// fifo8x9_ctrl_if
//   Bundles the producer/consumer handshake and the FIFO8x9 memory-side
//   controls of fifo8x9_ctrl.
//   slave  : the controller (drives acks, dout, memory strobes, status)
//   master : the surrounding system (drives requests, din, flush, DataOut)
//   Signals:
//     push_req/din/push_ack     producer write handshake
//     pop_req/pop_ack/dout      consumer read handshake
//     flush                     clear pointers and count
//     DataOut/DataIn            read data from / write data to FIFO8x9
//     wren/WrInc/rden/RdInc     single-hot memory strobes
//     RdPtrClr/WrPtrClr         pointer clears
//     count/full/empty/busy     occupancy and activity status
interface fifo8x9_ctrl_if #(
   parameter int unsigned WIDTH = 9,
   parameter int unsigned CNT_W = 4
);
   logic             push_req;
   logic [WIDTH-1:0] din;
   logic             pop_req;
   logic             flush;
   logic [WIDTH-1:0] DataOut;
   logic             push_ack;
   logic             pop_ack;
   logic [WIDTH-1:0] dout;
   logic [WIDTH-1:0] DataIn;
   logic             wren;
   logic             WrInc;
   logic             rden;
   logic             RdInc;
   logic             RdPtrClr;
   logic             WrPtrClr;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             empty;
   logic             busy;

   modport slave (
      input  push_req, din, pop_req, flush, DataOut,
      output push_ack, pop_ack, dout, DataIn,
             wren, WrInc, rden, RdInc, RdPtrClr, WrPtrClr,
             count, full, empty, busy
   );

   modport master (
      output push_req, din, pop_req, flush, DataOut,
      input  push_ack, pop_ack, dout, DataIn,
             wren, WrInc, rden, RdInc, RdPtrClr, WrPtrClr,
             count, full, empty, busy
   );
endinterface

// File: rtl/fifo8x9_ctrl.sv
// fifo8x9_ctrl
//   Sequencing controller for the 8 x 9 FIFO8x9 memory. Turns push/pop
//   request/ack handshakes into single-hot memory controls, tracks
//   occupancy and holds write data and popped data in registers.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-high reset
//     bus  fifo8x9_ctrl_if.slave (handshakes, memory strobes, status)
//   All outputs are registers loaded from a decode of the next state.
module fifo8x9_ctrl #(
   parameter int unsigned WIDTH = 9,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned CNT_W = 4
) (
   input logic           clk,
   input logic           rst,
   fifo8x9_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      WR,
      WR_INC,
      RD,
      RD_INC,
      CLR_RD,
      CLR_WR
   } state_t;

   typedef enum logic {
      PRIO_POP,
      PRIO_PUSH
   } prio_t;

   state_t           state_q, state_d;
   prio_t            prio_q, prio_d;
   logic             init_q, init_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             busy_q, busy_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic [WIDTH-1:0] data_in_q, data_in_d;
   logic             wren_q, wren_d;
   logic             wr_inc_q, wr_inc_d;
   logic             rden_q, rden_d;
   logic             rd_inc_q, rd_inc_d;
   logic             rd_ptr_clr_q, rd_ptr_clr_d;
   logic             wr_ptr_clr_q, wr_ptr_clr_d;
   logic             push_ack_q, push_ack_d;
   logic             pop_ack_q, pop_ack_d;

   logic push_ok;
   logic pop_ok;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= CLR_RD;
         init_q       <= 1'b1;
         prio_q       <= PRIO_POP;
         count_q      <= '0;
         full_q       <= 1'b0;
         empty_q      <= 1'b1;
         busy_q       <= 1'b1;
         dout_q       <= '0;
         data_in_q    <= '0;
         wren_q       <= 1'b0;
         wr_inc_q     <= 1'b0;
         rden_q       <= 1'b0;
         rd_inc_q     <= 1'b0;
         rd_ptr_clr_q <= 1'b0;
         wr_ptr_clr_q <= 1'b0;
         push_ack_q   <= 1'b0;
         pop_ack_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         init_q       <= init_d;
         prio_q       <= prio_d;
         count_q      <= count_d;
         full_q       <= full_d;
         empty_q      <= empty_d;
         busy_q       <= busy_d;
         dout_q       <= dout_d;
         data_in_q    <= data_in_d;
         wren_q       <= wren_d;
         wr_inc_q     <= wr_inc_d;
         rden_q       <= rden_d;
         rd_inc_q     <= rd_inc_d;
         rd_ptr_clr_q <= rd_ptr_clr_d;
         wr_ptr_clr_q <= wr_ptr_clr_d;
         push_ack_q   <= push_ack_d;
         pop_ack_q    <= pop_ack_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      prio_d  = prio_q;
      init_d  = init_q;
      push_ok = bus.push_req & ~full_q;
      pop_ok  = bus.pop_req & ~empty_q;

      case (state_q)
         IDLE: begin
            if (bus.flush) begin
               state_d = CLR_RD;
            end else if (push_ok && pop_ok) begin
               // Contended cycle: serve the favoured side, favour the other next time.
               if (prio_q == PRIO_POP) begin
                  state_d = RD;
                  prio_d  = PRIO_PUSH;
               end else begin
                  state_d = WR;
                  prio_d  = PRIO_POP;
               end
            end else if (push_ok) begin
               state_d = WR;
            end else if (pop_ok) begin
               state_d = RD;
            end
         end
         WR:     state_d = WR_INC;
         WR_INC: state_d = IDLE;
         RD:     state_d = RD_INC;
         RD_INC: state_d = IDLE;
         CLR_RD: begin
            // Reset parks here with the strobes forced low; the extra pass
            // lets the registered RdPtrClr actually pulse before CLR_WR.
            if (init_q) begin
               init_d = 1'b0;
            end else begin
               state_d = CLR_WR;
            end
         end
         CLR_WR: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Output / datapath decode (loaded into the output registers)
   // ------------------------------------------------------------------
   always_comb begin
      wren_d       = (state_d == WR);
      wr_inc_d     = (state_d == WR_INC);
      rden_d       = (state_d == RD);
      rd_inc_d     = (state_d == RD_INC);
      rd_ptr_clr_d = (state_d == CLR_RD);
      wr_ptr_clr_d = (state_d == CLR_WR);
      push_ack_d   = (state_d == WR_INC);
      pop_ack_d    = (state_d == RD_INC);
      busy_d       = (state_d != IDLE);

      count_d = count_q;
      case (state_d)
         WR_INC: if (count_q != CNT_W'(DEPTH)) count_d = count_q + CNT_W'(1);
         RD_INC: if (count_q != '0)            count_d = count_q - CNT_W'(1);
         CLR_WR: count_d = '0;
         default: count_d = count_q;
      endcase
      full_d  = (count_d == CNT_W'(DEPTH));
      empty_d = (count_d == '0);

      data_in_d = data_in_q;
      if (state_q == IDLE && state_d == WR) begin
         data_in_d = bus.din;
      end

      // The memory presents its word while rden is high, i.e. during RD.
      dout_d = dout_q;
      if (state_q == RD) begin
         dout_d = bus.DataOut;
      end
   end

   assign bus.push_ack = push_ack_q;
   assign bus.pop_ack  = pop_ack_q;
   assign bus.dout     = dout_q;
   assign bus.DataIn   = data_in_q;
   assign bus.wren     = wren_q;
   assign bus.WrInc    = wr_inc_q;
   assign bus.rden     = rden_q;
   assign bus.RdInc    = rd_inc_q;
   assign bus.RdPtrClr = rd_ptr_clr_q;
   assign bus.WrPtrClr = wr_ptr_clr_q;
   assign bus.count    = count_q;
   assign bus.full     = full_q;
   assign bus.empty    = empty_q;
   assign bus.busy     = busy_q;

endmodule

// File: tb/tb_fifo8x9_ctrl.sv
// tb_fifo8x9_ctrl
//   Drives fifo8x9_ctrl through directed and randomized push/pop/flush
//   traffic. A simple FIFO8x9 memory model answers the strobes, and a
//   word queue plus a pop/push preference bit predict acks, data and status.
module tb_fifo8x9_ctrl;
   localparam int unsigned W = 9;
   localparam int unsigned D = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fifo8x9_ctrl_if #(.WIDTH(W), .CNT_W(4)) bus ();

   fifo8x9_ctrl #(.WIDTH(W), .DEPTH(D), .CNT_W(4)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   // FIFO8x9 memory model
   logic [W-1:0] mem [D];
   logic [2:0]   wp = '0;
   logic [2:0]   rp = '0;
   always @(posedge clk) begin
      if (bus.wren)     mem[wp] <= bus.DataIn;
      if (bus.WrInc)    wp <= wp + 3'd1;
      if (bus.RdInc)    rp <= rp + 3'd1;
      if (bus.RdPtrClr) rp <= '0;
      if (bus.WrPtrClr) wp <= '0;
   end
   assign bus.DataOut = mem[rp];

   // Reference model
   logic [W-1:0] q[$];
   bit           prio_pop = 1'b1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      chk("onehot", 32'($countones({bus.wren, bus.WrInc, bus.rden, bus.RdInc,
                                    bus.RdPtrClr, bus.WrPtrClr}) <= 1), 32'd1);
   end

   task automatic check_status(input string tag);
      chk({tag, "_count"}, 32'(bus.count), 32'(q.size()));
      chk({tag, "_full"},  32'(bus.full),  32'(q.size() == D));
      chk({tag, "_empty"}, 32'(bus.empty), 32'(q.size() == 0));
   endtask

   task automatic check_realign();
      @(negedge clk);
      chk("realign_rdclr", 32'(bus.RdPtrClr), 32'd1);
      chk("realign_rdclr_wr", 32'(bus.WrPtrClr), 32'd0);
      @(negedge clk);
      chk("realign_wrclr", 32'(bus.WrPtrClr), 32'd1);
      chk("realign_wrclr_count", 32'(bus.count), 32'd0);
      @(negedge clk);
      chk("realign_busy", 32'(bus.busy), 32'd0);
      check_status("realign");
   endtask

   task automatic do_push(input logic [W-1:0] data);
      bit           saw_wren = 1'b0;
      bit           done = 1'b0;
      logic [W-1:0] wdat = 'x;
      bus.din = data;
      bus.push_req = 1'b1;
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge clk);
         if (bus.wren) begin
            saw_wren = 1'b1;
            wdat = bus.DataIn;
         end
         if (bus.push_ack) begin
            done = 1'b1;
            bus.push_req = 1'b0;
         end
      end
      bus.push_req = 1'b0;
      chk("push_ack", 32'(done), 32'd1);
      chk("push_wren", 32'(saw_wren), 32'd1);
      chk("push_data", 32'(wdat), 32'(data));
      if (done) q.push_back(data);
      check_status("push");
      @(negedge clk);
      chk("push_idle", 32'(bus.busy), 32'd0);
   endtask

   task automatic do_pop();
      bit           saw_rden = 1'b0;
      bit           done = 1'b0;
      logic [W-1:0] exp = q[0];
      bus.pop_req = 1'b1;
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge clk);
         if (bus.rden) saw_rden = 1'b1;
         if (bus.pop_ack) begin
            done = 1'b1;
            bus.pop_req = 1'b0;
            chk("pop_dout", 32'(bus.dout), 32'(exp));
         end
      end
      bus.pop_req = 1'b0;
      chk("pop_ack", 32'(done), 32'd1);
      chk("pop_rden", 32'(saw_rden), 32'd1);
      if (done) void'(q.pop_front());
      check_status("pop");
      @(negedge clk);
      chk("pop_idle", 32'(bus.busy), 32'd0);
   endtask

   task automatic blocked(input bit is_push, input int n);
      bit bad = 1'b0;
      bus.din = 9'h155;
      if (is_push) bus.push_req = 1'b1;
      else         bus.pop_req = 1'b1;
      repeat (n) begin
         @(negedge clk);
         if (bus.wren | bus.WrInc | bus.rden | bus.RdInc | bus.push_ack | bus.pop_ack)
            bad = 1'b1;
      end
      bus.push_req = 1'b0;
      bus.pop_req = 1'b0;
      chk(is_push ? "blocked_push" : "blocked_pop", 32'(bad), 32'd0);
      check_status("blocked");
   endtask

   // Push and pop requested together; only used with 1..D-1 words stored.
   task automatic do_both(input logic [W-1:0] data);
      bit exp_pop_first = prio_pop;
      bit push_done = 1'b0;
      bit pop_done = 1'b0;
      bit pop_first = 1'b0;
      logic [W-1:0] exp;
      prio_pop = !prio_pop;
      bus.din = data;
      bus.push_req = 1'b1;
      bus.pop_req = 1'b1;
      for (int c = 0; c < 40 && !(push_done && pop_done); c++) begin
         @(negedge clk);
         if (bus.push_ack) begin
            push_done = 1'b1;
            bus.push_req = 1'b0;
            q.push_back(data);
         end
         if (bus.pop_ack) begin
            if (!push_done) pop_first = 1'b1;
            pop_done = 1'b1;
            bus.pop_req = 1'b0;
            exp = q.pop_front();
            chk("both_dout", 32'(bus.dout), 32'(exp));
         end
      end
      bus.push_req = 1'b0;
      bus.pop_req = 1'b0;
      chk("both_done", 32'(push_done && pop_done), 32'd1);
      chk("both_order", 32'(pop_first), 32'(exp_pop_first));
      check_status("both");
      @(negedge clk);
   endtask

   task automatic do_flush();
      bus.flush = 1'b1;
      @(negedge clk);
      chk("flush_rdclr", 32'(bus.RdPtrClr), 32'd1);
      bus.flush = 1'b0;
      @(negedge clk);
      chk("flush_wrclr", 32'(bus.WrPtrClr), 32'd1);
      chk("flush_count", 32'(bus.count), 32'd0);
      q.delete();
      @(negedge clk);
      chk("flush_busy", 32'(bus.busy), 32'd0);
      check_status("flush");
   endtask

   initial begin
      bit got;
      bus.push_req = 1'b0;
      bus.pop_req  = 1'b0;
      bus.flush    = 1'b0;
      bus.din      = '0;

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_strobes", 32'({bus.wren, bus.WrInc, bus.rden, bus.RdInc,
                              bus.RdPtrClr, bus.WrPtrClr, bus.push_ack, bus.pop_ack}), 32'd0);
      chk("rst_count", 32'(bus.count), 32'd0);
      chk("rst_empty", 32'(bus.empty), 32'd1);
      chk("rst_full",  32'(bus.full),  32'd0);
      chk("rst_dout",  32'(bus.dout),  32'd0);
      chk("rst_datain", 32'(bus.DataIn), 32'd0);
      rst = 1'b0;
      check_realign();

      // Single push, then contention with three words stored
      do_push(9'h1A5);
      do_push(9'h0B2);
      do_push(9'h0C3);
      do_both(9'h0D4);   // pop favoured first after reset
      do_both(9'h0E5);   // push favoured now
      do_push(9'h011);
      do_push(9'h022);
      do_flush();        // flush with five words stored

      // Fill, overfill, drain, underflow
      for (int i = 0; i < 8; i++) do_push(W'(i));
      blocked(1'b1, 10);
      for (int i = 0; i < 8; i++) do_pop();
      blocked(1'b0, 6);

      // Randomized traffic
      for (int it = 0; it < 150; it++) begin
         int op = int'($urandom_range(0, 9));
         logic [W-1:0] d = W'($urandom);
         if (op < 4) begin
            if (q.size() == D) blocked(1'b1, 3);
            else do_push(d);
         end else if (op < 7) begin
            if (q.size() == 0) blocked(1'b0, 3);
            else do_pop();
         end else if (op < 9) begin
            if (q.size() > 0 && q.size() < D) do_both(d);
            else if (q.size() == 0) do_push(d);
            else do_pop();
         end else begin
            do_flush();
         end
      end

      // Reset during a write
      bus.din = 9'h0AA;
      bus.push_req = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         if (bus.wren) got = 1'b1;
      end
      chk("midwr_wren", 32'(got), 32'd1);
      rst = 1'b1;
      #1;
      bus.push_req = 1'b0;
      chk("midwr_strobes", 32'({bus.wren, bus.WrInc, bus.rden, bus.RdInc,
                                bus.RdPtrClr, bus.WrPtrClr, bus.push_ack, bus.pop_ack}), 32'd0);
      chk("midwr_count", 32'(bus.count), 32'd0);
      q.delete();
      prio_pop = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_realign();
      do_push(9'h133);
      do_pop();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
